// File: rtl/clock_gate_enable_ctrl.sv
// Enable controller for one gated clock domain: gates the domain clock after an
// idle period and re-enables it, with a settle delay, on a wake request.
module clock_gate_enable_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic       CLK_IN,
    input  logic       RESET,
    input  logic       BUSY,
    input  logic       WAKE_REQ,
    input  logic       FORCE_ON,
    output logic       ENABLE,
    output logic       WAKE_ACK,
    output logic       GATED,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        IDLE_WAIT = 2'b01,
        OFF       = 2'b10,
        WAKE      = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] IDLE_LOAD = CNT_WIDTH'(IDLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WAKE_LOAD = CNT_WIDTH'(WAKE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t               state;
    logic [CNT_WIDTH-1:0] counter;
    logic                 ack_done;
    logic                 idle;
    logic                 ack_now;

    assign idle    = !BUSY && !WAKE_REQ && !FORCE_ON;
    assign ack_now = WAKE_REQ && !ack_done;
    assign STATE   = state;

    // ENABLE and GATED are set on the same edge as the state change so the
    // downstream gate sees a register output that never glitches.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET) begin
            state    <= RUN;
            counter  <= '0;
            ack_done <= 1'b0;
            ENABLE   <= 1'b1;
            GATED    <= 1'b0;
            WAKE_ACK <= 1'b0;
        end else begin
            WAKE_ACK <= 1'b0;
            if (!WAKE_REQ) begin
                ack_done <= 1'b0;
            end

            case (state)
                RUN: begin
                    if (ack_now) begin
                        WAKE_ACK <= 1'b1;
                        ack_done <= 1'b1;
                    end
                    if (idle) begin
                        state   <= IDLE_WAIT;
                        counter <= IDLE_LOAD;
                    end
                end

                IDLE_WAIT: begin
                    if (ack_now) begin
                        WAKE_ACK <= 1'b1;
                        ack_done <= 1'b1;
                    end
                    if (!idle) begin
                        state <= RUN;
                    end else if (counter != '0) begin
                        counter <= counter - CNT_ONE;
                    end else begin
                        state  <= OFF;
                        ENABLE <= 1'b0;
                        GATED  <= 1'b1;
                    end
                end

                OFF: begin
                    // The domain is frozen, so BUSY carries no information here.
                    if (WAKE_REQ || FORCE_ON) begin
                        state   <= WAKE;
                        counter <= WAKE_LOAD;
                        ENABLE  <= 1'b1;
                        GATED   <= 1'b0;
                    end
                end

                WAKE: begin
                    if (counter != '0) begin
                        counter <= counter - CNT_ONE;
                    end else begin
                        state <= RUN;
                        if (ack_now) begin
                            WAKE_ACK <= 1'b1;
                            ack_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_gate_enable_ctrl.sv
// Directed bench for clock_gate_enable_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_clock_gate_enable_ctrl;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       wake_req;
    logic       force_on;
    logic       enable;
    logic       wake_ack;
    logic       gated;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    clock_gate_enable_ctrl #(
        .IDLE_CYCLES(4),
        .WAKE_CYCLES(2),
        .CNT_WIDTH  (8)
    ) dut (
        .CLK_IN  (clk),
        .RESET   (rst),
        .BUSY    (busy),
        .WAKE_REQ(wake_req),
        .FORCE_ON(force_on),
        .ENABLE  (enable),
        .WAKE_ACK(wake_ack),
        .GATED   (gated),
        .STATE   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [1:0] st, input logic en,
                              input logic gt, input logic ak);
        check({tag, ".state"}, state, st);
        check({tag, ".enable"}, {1'b0, enable}, {1'b0, en});
        check({tag, ".gated"}, {1'b0, gated}, {1'b0, gt});
        check({tag, ".ack"}, {1'b0, wake_ack}, {1'b0, ak});
    endtask

    initial begin
        rst      = 1'b1;
        busy     = 1'b0;
        wake_req = 1'b0;
        force_on = 1'b0;
        #3;
        expect_all("reset", 2'b00, 1'b1, 1'b0, 1'b0);

        // Idle after reset: IDLE_WAIT at edge 0, gated after edge 4.
        @(negedge clk);
        rst = 1'b0;
        tick();
        expect_all("edge0", 2'b01, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_all("idle_count", 2'b01, 1'b1, 1'b0, 1'b0);
        end
        tick();
        expect_all("gate_off", 2'b10, 1'b0, 1'b1, 1'b0);

        // Wake request from OFF: WAKE at t, ACK after t+2.
        wake_req = 1'b1;
        tick();
        expect_all("wake_t", 2'b11, 1'b1, 1'b0, 1'b0);
        tick();
        expect_all("wake_t1", 2'b11, 1'b1, 1'b0, 1'b0);
        tick();
        expect_all("wake_ack", 2'b00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_all("hold_req", 2'b00, 1'b1, 1'b0, 1'b0);
        end

        // BUSY pulse in IDLE_WAIT with counter=1 restarts the full count.
        wake_req = 1'b0;
        busy     = 1'b1;
        tick();
        expect_all("req_drop", 2'b00, 1'b1, 1'b0, 1'b0);
        busy = 1'b0;
        tick();
        tick();
        tick();
        expect_all("cnt_one", 2'b01, 1'b1, 1'b0, 1'b0);
        busy = 1'b1;
        tick();
        expect_all("busy_pulse", 2'b00, 1'b1, 1'b0, 1'b0);
        busy = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            tick();
            expect_all("recount", 2'b01, 1'b1, 1'b0, 1'b0);
        end
        tick();
        expect_all("regate", 2'b10, 1'b0, 1'b1, 1'b0);

        // FORCE_ON alone in OFF: wakes without ACK, then holds RUN.
        force_on = 1'b1;
        tick();
        expect_all("force_wake", 2'b11, 1'b1, 1'b0, 1'b0);
        tick();
        expect_all("force_wake1", 2'b11, 1'b1, 1'b0, 1'b0);
        tick();
        expect_all("force_run", 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick();
            expect_all("force_hold", 2'b00, 1'b1, 1'b0, 1'b0);
        end

        // Back to OFF, start a wake, then reset mid-WAKE with counter=1.
        force_on = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        expect_all("off_again", 2'b10, 1'b0, 1'b1, 1'b0);
        wake_req = 1'b1;
        tick();
        expect_all("wake_pre_rst", 2'b11, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_all("async_rst", 2'b00, 1'b1, 1'b0, 1'b0);
        wake_req = 1'b0;
        busy     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        expect_all("post_rst0", 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_all("post_rst1", 2'b00, 1'b1, 1'b0, 1'b0);
        wake_req = 1'b1;
        tick();
        expect_all("rereq_ack", 2'b00, 1'b1, 1'b0, 1'b1);
        tick();
        expect_all("rereq_done", 2'b00, 1'b1, 1'b0, 1'b0);

        // WAKE_REQ rises as BUSY falls in RUN: stay in RUN and ACK.
        wake_req = 1'b0;
        tick();
        expect_all("clr_ack_done", 2'b00, 1'b1, 1'b0, 1'b0);
        busy     = 1'b0;
        wake_req = 1'b1;
        tick();
        expect_all("simul_ack", 2'b00, 1'b1, 1'b0, 1'b1);
        tick();
        expect_all("simul_after", 2'b00, 1'b1, 1'b0, 1'b0);
        wake_req = 1'b0;
        tick();
        expect_all("drop_req", 2'b01, 1'b1, 1'b0, 1'b0);
        wake_req = 1'b1;
        tick();
        expect_all("second_ack", 2'b00, 1'b1, 1'b0, 1'b1);
        tick();
        expect_all("second_after", 2'b00, 1'b1, 1'b0, 1'b0);

        // WAKE_REQ together with FORCE_ON in OFF: ACK at WAKE exit.
        wake_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        expect_all("off_third", 2'b10, 1'b0, 1'b1, 1'b0);
        wake_req = 1'b1;
        force_on = 1'b1;
        tick();
        expect_all("both_wake", 2'b11, 1'b1, 1'b0, 1'b0);
        tick();
        expect_all("both_wake1", 2'b11, 1'b1, 1'b0, 1'b0);
        tick();
        expect_all("both_ack", 2'b00, 1'b1, 1'b0, 1'b1);
        tick();
        expect_all("both_after", 2'b00, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
